hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core. Drives the Stall/Flush inputs of the F, D, E and M pipeline registers and the E-stage forwarding selects.
- Sequences load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
- Carries a data-memory watchdog and saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before a memory error is declared.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- Rs1D  in  5  decode-stage source register 1.
- Rs2D  in  5  decode-stage source register 2.
- Rs1E  in  5  execute-stage source register 1.
- Rs2E  in  5  execute-stage source register 2.
- RdE  in  5  execute-stage destination register.
- ResultSrcE  in  2  execute-stage result select; 2'b01 = load.
- RdM  in  5  memory-stage destination register.
- RegWriteM  in  1  memory-stage register write enable.
- RdW  in  5  writeback-stage destination register.
- RegWriteW  in  1  writeback-stage register write enable.
- PCSrcE  in  1  branch/jump taken, resolved in E.
- MemReqM  in  1  load or store present in M.
- MemReadyM  in  1  data memory completes the M access this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold D register.
- StallE  out  1  hold E register.
- StallM  out  1  hold M register.
- FlushD  out  1  clear D register.
- FlushE  out  1  clear E register.
- ForwardAE  out  2  operand A select: 00 regfile, 01 W result, 10 M ALU result.
- ForwardBE  out  2  operand B select; same encoding as ForwardAE.
- MemErr  out  1  sticky watchdog error.
- StallCycles  out  CNT_W  saturating count of cycles with StallD=1.
- FlushCount  out  CNT_W  saturating count of taken-branch flushes.

Behaviour:
- Timing split:
  - Outputs are combinational from the current inputs and the registered state.
  - State, wait counter, MemErr and the performance counters are registered.
- States: RUN, MEM_WAIT, ERR.
- Reset (rst=1 at a rising edge):
  - Next state is RUN; wait counter, MemErr, StallCycles and FlushCount become 0.
  - While rst is high, outputs are forced to FlushD=FlushE=1, all stalls 0, forwards 00.
- Forwarding (evaluated in every state; ForwardBE is identical using Rs2E):
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else 00. M has priority over W.
- RUN state, decisions in priority order:
  1. Memory wait: MemReqM=1 & MemReadyM=0 → StallF=StallD=StallE=StallM=1, no flush; next state MEM_WAIT, wait counter <=1. PCSrcE and load-use are ignored this cycle because E is frozen.
  2. Taken branch: PCSrcE=1 → FlushD=FlushE=1, stalls 0, FlushCount+1. This overrides load-use, since the load's dependent instruction is discarded.
  3. Load-use: ResultSrcE==01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) → StallF=StallD=1, FlushE=1, StallE=StallM=0. Exactly one bubble.
  4. Otherwise: all stall and flush outputs 0.
- MEM_WAIT state:
  - MemReadyM=0: all four stalls 1, no flush, wait counter +1.
  - Wait counter reaching MEM_TIMEOUT: MemErr <=1, next state ERR.
  - MemReadyM=1: stalls released this same cycle and RUN rules 2–4 apply to the current inputs; next state RUN, wait counter <=0.
- ERR state:
  - All four stalls held at 1, flushes 0, MemErr=1.
  - Only rst exits ERR.
- Performance counters:
  - StallCycles increments in every non-reset cycle with StallD=1.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-MEM_WAIT or in ERR returns the block to RUN on the next edge; any pending memory access is abandoned.

Test Plan:
- Load-use: `lw x5` in E (ResultSrcE=01, RdE=5) with Rs1D=5 → one cycle of StallF=StallD=FlushE=1; next cycle all 0; StallCycles=1.
- Forward priority: RdM=RdW=7, both RegWriteM and RegWriteW set, Rs1E=7 → ForwardAE=10; then RegWriteM=0 → 01; then Rs1E=0 with RdM=0 → 00.
- Branch vs load-use: PCSrcE=1 in the same cycle as a load-use match → FlushD=FlushE=1, StallF=StallD=0, FlushCount=1.
- Memory wait: MemReqM=1 with MemReadyM low for 3 cycles, then high → all stalls high for 3 cycles, released in the ready cycle; state returns to RUN and MemErr stays 0.
- Watchdog: MEM_TIMEOUT=4, MemReadyM held low → MemErr=1 after the 4th wait cycle and stalls stay high indefinitely; rst pulse → MemErr=0, state RUN, counters 0.
- Saturation: CNT_W=4, StallD forced high for 20 cycles → StallCycles saturates and holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage RISC-V core.
//
// Produces the Stall/Flush controls for the F, D, E and M pipeline registers
// and the E-stage operand forwarding selects. It sequences:
//   - load-use stalls (one bubble),
//   - taken-branch flushes (resolved in E),
//   - multi-cycle data-memory waits, guarded by a watchdog.
// It also keeps saturating performance counters for stalls and flushes.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   Rs1D, Rs2D            decode-stage source registers
//   Rs1E, Rs2E, RdE       execute-stage source/destination registers
//   ResultSrcE            execute-stage result select (2'b01 = load)
//   RdM, RegWriteM        memory-stage destination and write enable
//   RdW, RegWriteW        writeback-stage destination and write enable
//   PCSrcE                branch/jump taken in E
//   MemReqM, MemReadyM    data-memory request present / access completes
//   StallF/D/E/M          hold the PC and the D/E/M registers
//   FlushD/E              clear the D/E registers
//   ForwardAE/BE          00 regfile, 01 W result, 10 M ALU result
//   MemErr                sticky watchdog error
//   StallCycles           saturating count of cycles with StallD=1
//   FlushCount            saturating count of taken-branch flushes
//
// All control outputs are combinational from the inputs and registered state.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t           state;
  logic [WC_W-1:0]  wait_cnt;
  logic [WC_W-1:0]  wait_cnt_inc;
  logic             mem_err;
  logic             load_use;
  logic             mem_block;
  logic             branch_flush;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic       we_m,
                                         input logic [4:0] rd_w,
                                         input logic       we_w);
    if (we_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign wait_cnt_inc = wait_cnt + WC_W'(1);
  assign MemErr       = mem_err;

  always_comb begin
    load_use = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));

    // Everything frozen: an outstanding memory access in RUN, a still-pending
    // one in MEM_WAIT, or the error state. A frozen E ignores branch/load-use.
    case (state)
      RUN:      mem_block = MemReqM && !MemReadyM;
      MEM_WAIT: mem_block = !MemReadyM;
      default:  mem_block = 1'b1;
    endcase

    branch_flush = !rst && !mem_block && PCSrcE;

    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;

    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (mem_block) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        // The load's dependent instruction is discarded, so no stall needed.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_err     <= 1'b0;
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallD)       StallCycles <= sat_inc(StallCycles);
      if (branch_flush) FlushCount  <= sat_inc(FlushCount);

      case (state)
        RUN: begin
          if (MemReqM && !MemReadyM) begin
            wait_cnt <= WC_W'(1);
            if (MEM_TIMEOUT <= 1) begin
              state   <= ERR;
              mem_err <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (MemReadyM) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc >= WC_W'(MEM_TIMEOUT)) begin
              state   <= ERR;
              mem_err <= 1'b1;
            end
          end
        end
        ERR: mem_err <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule
